// File: rtl/mult.sv
// Sequential 32x32 signed radix-2 Booth multiplier, one iteration per clock, HI/LO result.
// Optional MULT_ZERO_SKIP_EN: zero operands finish after a single cycle.
module mult (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        multControl,
  output logic        multStop,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [32:0] r_m, w_m_d;
  logic [32:0] r_acc, w_acc_d;
  logic [31:0] r_q, w_q_d;
  logic        r_qm1, w_qm1_d;
  logic [5:0]  r_cnt, w_cnt_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic        r_stop, w_stop_d;

  logic [32:0] w_sum;
  logic [32:0] w_acc_sh;
  logic [31:0] w_q_sh;

  always_comb begin
    w_sum = r_acc;
    unique case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
  end

  // Arithmetic right shift of {ACC, Q, Qm1}; Qm1 picks up the old Q[0].
  assign w_acc_sh = {w_sum[32], w_sum[32:1]};
  assign w_q_sh   = {w_sum[0], r_q[31:1]};

  always_comb begin
    w_state_d = r_state;
    w_m_d     = r_m;
    w_acc_d   = r_acc;
    w_q_d     = r_q;
    w_qm1_d   = r_qm1;
    w_cnt_d   = r_cnt;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_stop_d  = r_stop;

    if (multControl) begin
      w_m_d     = {a[31], a};
      w_acc_d   = 33'd0;
      w_q_d     = b;
      w_qm1_d   = 1'b0;
      w_cnt_d   = 6'd32;
      w_hi_d    = 32'd0;
      w_lo_d    = 32'd0;
      w_stop_d  = 1'b0;
      w_state_d = StRun;
`ifdef MULT_ZERO_SKIP_EN
      // A single all-zero iteration yields a zero product and completes on the next edge.
      if ((a == 32'd0) || (b == 32'd0)) begin
        w_m_d   = 33'd0;
        w_q_d   = 32'd0;
        w_cnt_d = 6'd1;
      end
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StIdle;
        end
        StRun: begin
          w_acc_d = w_acc_sh;
          w_q_d   = w_q_sh;
          w_qm1_d = r_q[0];
          w_cnt_d = r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            w_hi_d    = w_acc_sh[31:0];
            w_lo_d    = w_q_sh;
            w_stop_d  = 1'b1;
            w_state_d = StDone;
          end
        end
        StDone: begin
          w_stop_d  = 1'b0;
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_m     <= 33'd0;
      r_acc   <= 33'd0;
      r_q     <= 32'd0;
      r_qm1   <= 1'b0;
      r_cnt   <= 6'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_m     <= w_m_d;
      r_acc   <= w_acc_d;
      r_q     <= w_q_d;
      r_qm1   <= w_qm1_d;
      r_cnt   <= w_cnt_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_stop  <= w_stop_d;
    end
  end

  assign multStop = r_stop;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: scoreboard of exact signed products, latency and handshake checks.
module tb_mult;

`ifdef MULT_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 32;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        multControl;
  logic        multStop;
  logic [31:0] hi;
  logic [31:0] lo;

  mult dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .multControl(multControl),
    .multStop   (multStop),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_stops = 0;
  int          cyc = 0;
  int          last_stop_cyc = 0;
  int          t_start = 0;
  int          base;
  logic [63:0] sb[$];
  logic [63:0] e;

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] xs;
    logic signed [63:0] ys;
    xs = {{32{x[31]}}, x};
    ys = {{32{y[31]}}, y};
    return xs * ys;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Cycle counter and output monitor, sampled just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (multStop === 1'b1) begin
      n_stops++;
      last_stop_cyc = cyc;
      check("stop_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e[63:32]));
        check("lo", 64'(lo), 64'(e[31:0]));
      end
    end
  end

  // Called at a negedge: the next rising edge is the start edge.
  task automatic drive_start(input logic [31:0] x, input logic [31:0] y, input bit push);
    a = x;
    b = y;
    multControl = 1'b1;
    @(negedge clk);
    multControl = 1'b0;
    t_start = cyc;
    a = $urandom;
    b = $urandom;
    if (push) sb.push_back(prod(x, y));
  endtask

  task automatic start(input logic [31:0] x, input logic [31:0] y, input bit push);
    @(negedge clk);
    drive_start(x, y, push);
  endtask

  task automatic wait_done(input int lat, input bit chk_low);
    int n0;
    bit seen;
    n0 = n_stops;
    seen = 1'b0;
    for (int i = 0; i < 45 && !seen; i++) begin
      @(negedge clk);
      if (n_stops != n0) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    if (seen) check("latency", 64'(last_stop_cyc - t_start), 64'(lat));
    if (chk_low) begin
      @(negedge clk);
      check("stop_one_cycle", 64'(multStop), 64'd0);
    end
  endtask

  logic [31:0] op_a[4];
  logic [31:0] op_b[4];

  initial begin
    op_a = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_1234};
    op_b = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0F0F_F0F0};
    reset = 1'b1;
    multControl = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(negedge clk);
    // Reset and start on the same edge: reset wins.
    multControl = 1'b1;
    a = 32'd7;
    b = 32'd6;
    @(negedge clk);
    reset = 1'b0;
    multControl = 1'b0;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_stop", 64'(multStop), 64'd0);
    repeat (36) @(negedge clk);
    check("no_start_under_reset", 64'(n_stops), 64'd0);

    start(32'd7, 32'd6, 1'b1);
    wait_done(32, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_hi", 64'(hi), 64'h0);
    check("hold_lo", 64'(lo), 64'h2A);

    start(32'd0, 32'h1234, 1'b1);
    wait_done(ZLAT, 1'b1);
    start(32'h1234, 32'd0, 1'b1);
    wait_done(ZLAT, 1'b1);

    for (int i = 0; i < 4; i++) begin
      start(op_a[i], op_b[i], 1'b1);
      wait_done(32, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      start($urandom, $urandom, 1'b1);
      wait_done(32, 1'b1);
    end
    start(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    wait_done(32, 1'b1);

    // Reset at T+10 aborts the operation with no done pulse.
    base = n_stops;
    start(32'd7, 32'd6, 1'b0);
    check("start_clears_hi", 64'(hi), 64'd0);
    check("start_clears_lo", 64'(lo), 64'd0);
    repeat (8) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_stop", 64'(multStop), 64'd0);
    repeat (30) @(negedge clk);
    check("abort_no_stop", 64'(n_stops - base), 64'd0);

    // Restart at T+20 drops the first operation.
    base = n_stops;
    start(32'd7, 32'd6, 1'b0);
    repeat (18) @(negedge clk);
    start(32'd3, 32'd3, 1'b1);
    wait_done(32, 1'b1);
    check("restart_single_stop", 64'(n_stops - base), 64'd1);

    // Restart exactly on the completion edge.
    base = n_stops;
    start(32'd7, 32'd6, 1'b0);
    repeat (30) @(negedge clk);
    start(32'd2, 32'hFFFF_FFFD, 1'b1);
    check("restart_clr_lo", 64'(lo), 64'd0);
    wait_done(32, 1'b1);
    check("complete_restart_stop", 64'(n_stops - base), 64'd1);

    // Strobe held high restarts every edge.
    base = n_stops;
    @(negedge clk);
    a = 32'd5;
    b = 32'd9;
    multControl = 1'b1;
    repeat (5) @(negedge clk);
    multControl = 1'b0;
    t_start = cyc;
    sb.push_back(prod(32'd5, 32'd9));
    wait_done(32, 1'b1);
    check("held_single_stop", 64'(n_stops - base), 64'd1);

    // A start during the DONE cycle is accepted.
    start(32'd11, 32'd13, 1'b1);
    wait_done(32, 1'b0);
    drive_start(32'hFFFF_FFF9, 32'd100, 1'b1);
    wait_done(32, 1'b1);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
